// File: rtl/gf180mcu_fd_sc_mcu7t5v0__regbank_sn.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__regbank_sn
// Small flop-based register bank with bit-masked writes, a synchronous
// "set to all-ones" control, a registered write-through read port, a sticky
// error flag and a saturating count of committed writes.
//
// Ports
//   CLK      in   1      clock, all state updates on the rising edge
//   RN       in   1      asynchronous active-low reset
//   E        in   1      write enable
//   A        in   AW     write address
//   D        in   WIDTH  write data
//   M        in   WIDTH  write bit mask, 1 = bit written
//   SETN     in   1      synchronous active-low set of all entries to ones
//   RA       in   AW     read address
//   CLR_ERR  in   1      clears ERR unless a new error occurs on the same edge
//   Q        out  WIDTH  registered read data
//   ERR      out  1      sticky error flag
//   WCNT     out  CW     saturating committed-write count
//   VDD/VSS  inout 1     supplies, no functional use
// CW must be at least 2.
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__regbank_sn #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             E,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] M,
  input  logic             SETN,
  input  logic [AW-1:0]    RA,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic             ERR,
  output logic [CW-1:0]    WCNT,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;
  logic             r_err;
  logic [CW-1:0]    r_wcnt;

  logic [WIDTH-1:0] w_mem_next [DEPTH];
  logic [WIDTH-1:0] w_q_next;
  logic             w_err_next;
  logic [CW-1:0]    w_wcnt_next;
  logic             w_err_evt;
  logic             w_wr_hit;
  logic             w_rd_hit;

  // Next-state for storage, counter, read data and error flag.
  // The case on {SETN,E} routes any X/Z on those controls to the default
  // branch, which flags an error and leaves storage untouched.
  always_comb begin
    w_mem_next  = r_mem;
    w_wcnt_next = r_wcnt;
    w_err_evt   = 1'b0;
    w_wr_hit    = 1'b0;
    w_rd_hit    = 1'b0;
    w_q_next    = ONES_W;

    case ({SETN, E})
      2'b00: begin
        for (int i = 0; i < DEPTH; i++) begin
          w_mem_next[i] = ONES_W;
        end
        w_wcnt_next = {CW{1'b0}};
      end
      2'b01: begin
        // Set/write conflict: set wins, the write is dropped and flagged.
        for (int i = 0; i < DEPTH; i++) begin
          w_mem_next[i] = ONES_W;
        end
        w_wcnt_next = {CW{1'b0}};
        w_err_evt   = 1'b1;
      end
      2'b10: begin
        w_err_evt = 1'b0;
      end
      2'b11: begin
        // Address decode by comparison so an out-of-range A never indexes
        // past the array for non-power-of-two depths.
        for (int i = 0; i < DEPTH; i++) begin
          if (A == i[AW-1:0]) begin
            w_mem_next[i] = (r_mem[i] & ~M) | (D & M);
            w_wr_hit      = 1'b1;
          end else begin
            w_mem_next[i] = r_mem[i];
          end
        end
        if (w_wr_hit) begin
          // A mask of zero still counts as a committed write.
          if (r_wcnt != CNT_MAX) begin
            w_wcnt_next = r_wcnt + CNT_ONE;
          end else begin
            w_wcnt_next = r_wcnt;
          end
        end else begin
          w_err_evt = 1'b1;
        end
      end
      default: begin
        w_err_evt = 1'b1;
      end
    endcase

    // Read port sees this edge's write/set result (write-through).
    for (int i = 0; i < DEPTH; i++) begin
      if (RA == i[AW-1:0]) begin
        w_q_next = w_mem_next[i];
        w_rd_hit = 1'b1;
      end else begin
        w_rd_hit = w_rd_hit;
      end
    end
    if (!w_rd_hit) begin
      w_q_next  = ONES_W;
      w_err_evt = 1'b1;
    end else begin
      w_q_next = w_q_next;
    end

    // A new error takes priority over a clear on the same edge.
    if (w_err_evt) begin
      w_err_next = 1'b1;
    end else if (CLR_ERR) begin
      w_err_next = 1'b0;
    end else begin
      w_err_next = r_err;
    end
  end

  // State registers; reset drives entries and Q to ones, ERR and WCNT to zero.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= ONES_W;
      end
      r_q    <= ONES_W;
      r_err  <= 1'b0;
      r_wcnt <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_next[i];
      end
      r_q    <= w_q_next;
      r_err  <= w_err_next;
      r_wcnt <= w_wcnt_next;
    end
  end

  assign Q    = r_q;
  assign ERR  = r_err;
  assign WCNT = r_wcnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__regbank_sn.sv
// -----------------------------------------------------------------------------
// Directed testbench for gf180mcu_fd_sc_mcu7t5v0__regbank_sn, configured with
// WIDTH=4, DEPTH=3 (so address 3 is out of range) and CW=2 (saturates at 3).
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu7t5v0__regbank_sn;

  logic       CLK;
  logic       clk_en;
  logic       RN;
  logic       E;
  logic [1:0] A;
  logic [3:0] D;
  logic [3:0] M;
  logic       SETN;
  logic [1:0] RA;
  logic       CLR_ERR;
  logic [3:0] Q;
  logic       ERR;
  logic [1:0] WCNT;
  wire        VDD;
  wire        VSS;

  int n_vec;
  int n_bad;

  assign VDD = 1'b1;
  assign VSS = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__regbank_sn #(
    .WIDTH(4), .DEPTH(3), .AW(2), .CW(2)
  ) u_dut (
    .CLK(CLK), .RN(RN), .E(E), .A(A), .D(D), .M(M), .SETN(SETN),
    .RA(RA), .CLR_ERR(CLR_ERR), .Q(Q), .ERR(ERR), .WCNT(WCNT),
    .VDD(VDD), .VSS(VSS)
  );

  // Gated clock so reset can be exercised with no edges at all.
  initial CLK = 1'b0;
  always begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] q, input logic e, input logic [1:0] w);
    chk({tag, ".Q"}, {28'd0, Q}, {28'd0, q});
    chk({tag, ".ERR"}, {31'd0, ERR}, {31'd0, e});
    chk({tag, ".WCNT"}, {30'd0, WCNT}, {30'd0, w});
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic [3:0] m, input logic [1:0] ra);
    E = 1'b1; A = a; D = d; M = m; RA = ra;
    step();
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    clk_en = 1'b0;
    RN = 1'b1; E = 1'b0; A = 2'd0; D = 4'h0; M = 4'h0;
    SETN = 1'b1; RA = 2'd0; CLR_ERR = 1'b0;

    // Reset pulse with the clock stopped.
    #3 RN = 1'b0;
    #4;
    chk_all("reset", 4'hF, 1'b0, 2'd0);
    RN = 1'b1;
    #4;
    clk_en = 1'b1;

    // Read every entry after reset.
    for (int i = 0; i < 3; i++) begin
      RA = 2'(i);
      step();
      chk_all($sformatf("rd_reset%0d", i), 4'hF, 1'b0, 2'd0);
    end

    // Masked write with write-through: (F & ~3) | (5 & 3) = D.
    wr(2'd2, 4'h5, 4'h3, 2'd2);
    chk_all("mask_wr", 4'hD, 1'b0, 2'd1);
    // Zero mask still counts.
    wr(2'd0, 4'h0, 4'h0, 2'd0);
    chk_all("mask0_wr", 4'hF, 1'b0, 2'd2);
    wr(2'd1, 4'h6, 4'hF, 2'd1);
    chk_all("full_wr", 4'h6, 1'b0, 2'd3);
    wr(2'd0, 4'h3, 4'hF, 2'd0);
    chk_all("sat4", 4'h3, 1'b0, 2'd3);
    // (3 & 3) | (A & C) = B.
    wr(2'd0, 4'hA, 4'hC, 2'd0);
    chk_all("sat5", 4'hB, 1'b0, 2'd3);

    // Plain reads of the other entries.
    E = 1'b0; RA = 2'd2; step();
    chk_all("rd2", 4'hD, 1'b0, 2'd3);
    RA = 2'd1; step();
    chk_all("rd1", 4'h6, 1'b0, 2'd3);

    // Set/write conflict: set wins, error raised, counter cleared.
    E = 1'b1; SETN = 1'b0; A = 2'd1; D = 4'h0; M = 4'hF; RA = 2'd1;
    step();
    chk_all("conflict", 4'hF, 1'b1, 2'd0);
    E = 1'b0; SETN = 1'b1; CLR_ERR = 1'b1; RA = 2'd0;
    step();
    chk_all("clr_err", 4'hF, 1'b0, 2'd0);
    CLR_ERR = 1'b0;

    // Set without write: no error.
    wr(2'd0, 4'h2, 4'hF, 2'd0);
    chk_all("pre_set", 4'h2, 1'b0, 2'd1);
    E = 1'b0; SETN = 1'b0; RA = 2'd0;
    step();
    chk_all("set", 4'hF, 1'b0, 2'd0);
    SETN = 1'b1;

    // Out-of-range write leaves storage and counter alone.
    wr(2'd2, 4'h0, 4'hF, 2'd2);
    chk_all("pre_oor", 4'h0, 1'b0, 2'd1);
    wr(2'd3, 4'h5, 4'hF, 2'd2);
    chk_all("oor_wr", 4'h0, 1'b1, 2'd1);
    E = 1'b0; RA = 2'd1; step();
    chk_all("oor_sticky", 4'hF, 1'b1, 2'd1);
    // Out-of-range read on the clearing edge: the new error wins.
    CLR_ERR = 1'b1; RA = 2'd3; step();
    chk_all("oor_rd_clr", 4'hF, 1'b1, 2'd1);
    RA = 2'd0; step();
    chk_all("clr_ok", 4'hF, 1'b0, 2'd1);
    CLR_ERR = 1'b0;

    // Reset asserted between write setup and the edge.
    E = 1'b1; A = 2'd1; D = 4'h0; M = 4'hF; RA = 2'd1;
    #2 RN = 1'b0;
    #1;
    chk_all("rst_async", 4'hF, 1'b0, 2'd0);
    @(posedge CLK);
    #2;
    chk_all("rst_hold", 4'hF, 1'b0, 2'd0);
    RN = 1'b1; E = 1'b0;
    step();
    chk_all("rst_rd1", 4'hF, 1'b0, 2'd0);
    RA = 2'd2; step();
    chk_all("rst_rd2", 4'hF, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__regbank_sn.md
GF180MCU_FD_SC_MCU7T5V0__REGBANK_SN -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__regbank_sn

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bits per entry (1..32).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of entries (2..16).
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), meaning address width.
REQ-004 SHALL have parameter CW, default 8, meaning write-counter width.
REQ-005 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port RN  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port E  input  1  write enable.
REQ-008 SHALL have port A  input  AW  write address.
REQ-009 SHALL have port D  input  WIDTH  write data.
REQ-010 SHALL have port M  input  WIDTH  write bit mask; 1 = bit written.
REQ-011 SHALL have port SETN  input  1  synchronous set, active-low, all entries to ones.
REQ-012 SHALL have port RA  input  AW  read address.
REQ-013 SHALL have port CLR_ERR  input  1  clears ERR.
REQ-014 SHALL have port Q  output  WIDTH  registered read data.
REQ-015 SHALL have port ERR  output  1  sticky error flag.
REQ-016 SHALL have port WCNT  output  CW  committed-write count.
REQ-017 SHALL have ports VDD and VSS  inout  1  supplies, no functional use.

Function
REQ-018 SHALL implement DEPTH x WIDTH flop storage; no latches.
REQ-019 SHALL, on a rising CLK with SETN=1, E=1 and A<DEPTH, commit entry[A] <= (entry[A] & ~M) | (D & M).
REQ-020 SHALL count a write as committed when REQ-019 applies, even if M=0.
REQ-021 SHALL, on a rising CLK with SETN=0, set every entry to all-ones, ignore E/A/D/M, and clear WCNT to 0.
REQ-022 SHALL set ERR when SETN=0 and E=1 on the same edge (set/write conflict); set wins.
REQ-023 SHALL, on E=1, SETN=1, A>=DEPTH, write nothing, leave WCNT unchanged, set ERR.
REQ-024 SHALL update Q every rising CLK with latency 1: Q <= entry[RA] value after that edge's write/set (write-through).
REQ-025 SHALL, when RA>=DEPTH, drive Q <= all-ones and set ERR.
REQ-026 SHALL increment WCNT by 1 per committed write, saturating at 2^CW-1 (no wrap).
REQ-027 SHALL clear ERR on a rising CLK with CLR_ERR=1 unless a new error occurs on the same edge; new error wins.
REQ-028 SHALL treat X/Z on E or SETN as an error: ERR set, storage unchanged.
REQ-029 SHALL keep ERR, Q, WCNT stable between rising edges (all outputs registered).

Reset
REQ-030 SHALL, while RN=0, immediately force all entries to all-ones, Q to all-ones, ERR to 0, WCNT to 0, independent of CLK.
REQ-031 SHALL, on RN deassertion, perform no state change until the next rising CLK.
REQ-032 SHALL, on RN asserted mid-operation, abandon any in-flight write; no partial entry update.
REQ-033 SHALL ignore CLK edges coincident with RN=0.

Verification
REQ-034 SHALL cover reset: RN=0 pulse without CLK -> Q=4'hF, ERR=0, WCNT=0; read all RA -> 4'hF.
REQ-035 SHALL cover masked write: E=1,A=2,D=4'h5,M=4'h3,RA=2 -> next edge Q=4'hD, WCNT=1.
REQ-036 SHALL cover conflict: E=1,SETN=0,A=1,D=4'h0,M=4'hF -> entry1=4'hF, ERR=1, WCNT=0.
REQ-037 SHALL cover saturation: CW=2, 5 committed writes -> WCNT=3 after 3rd and stays 3.
REQ-038 SHALL cover out-of-range: DEPTH=3, E=1,A=3 -> no entry changes, ERR=1; CLR_ERR=1 with RA=3 same edge -> ERR stays 1, Q=4'hF.
REQ-039 SHALL cover async reset mid-write: RN=0 between E=1 setup and CLK edge -> entries 4'hF, WCNT=0 after release.
